// File: rtl/ktc16.sv
// KTC16: two-state multicycle 16-bit CPU (FETCH/EXEC) with a 16 x 16-bit register file.
// Define KTC16_MUL_EN to turn opcode 08 into a single-cycle unsigned MUL; otherwise 08 is a NOP.
module ktc16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rd,
  output logic        memwrite,
  output logic [15:0] addr,
  output logic [15:0] wd
);

  localparam int unsigned XLEN = 16;
  localparam int unsigned IW   = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned RIDX = 4;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_SLL  = 8'h06;
  localparam logic [7:0] OP_SRL  = 8'h07;
  localparam logic [7:0] OP_SLT  = 8'h09;
  localparam logic [7:0] OP_ADDI = 8'h10;
  localparam logic [7:0] OP_ANDI = 8'h12;
  localparam logic [7:0] OP_ORI  = 8'h13;
  localparam logic [7:0] OP_LW   = 8'h14;
  localparam logic [7:0] OP_SW   = 8'h15;
  localparam logic [7:0] OP_BEQ  = 8'h16;
  localparam logic [7:0] OP_BNE  = 8'h17;
  localparam logic [7:0] OP_JAL  = 8'h18;
`ifdef KTC16_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'h08;
`endif

  typedef enum logic {S_FETCH, S_EXEC} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic [7:0]      op;
  logic [RIDX-1:0] d_idx, s_idx;
  logic [XLEN-1:0] imm, rd_val, rs_val, ea, pc_plus4;
  logic            wr_en;
  logic [XLEN-1:0] wr_val;

  // Instruction field decode and operand read; r0 always reads zero.
  assign op       = ir_q[31:24];
  assign d_idx    = ir_q[23:20];
  assign s_idx    = ir_q[19:16];
  assign imm      = ir_q[15:0];
  assign rd_val   = (d_idx == RIDX'(0)) ? '0 : regs_q[d_idx];
  assign rs_val   = (s_idx == RIDX'(0)) ? '0 : regs_q[s_idx];
  assign ea       = rs_val + imm;
  assign pc_plus4 = pc_q + XLEN'(4);

`ifdef KTC16_MUL_EN
  logic [2*XLEN-1:0] mul_full;
  assign mul_full = (2*XLEN)'(rd_val) * (2*XLEN)'(rs_val);
`endif

  // Next-state, execute and memory-port logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    memwrite = 1'b0;
    addr     = pc_q;
    wd       = '0;
    wr_en    = 1'b0;
    wr_val   = '0;
    case (state_q)
      S_FETCH: begin
        ir_d    = rd;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        case (op)
          OP_ADD:  begin wr_en = 1'b1; wr_val = rd_val + rs_val; end
          OP_SUB:  begin wr_en = 1'b1; wr_val = rd_val - rs_val; end
          OP_AND:  begin wr_en = 1'b1; wr_val = rd_val & rs_val; end
          OP_OR:   begin wr_en = 1'b1; wr_val = rd_val | rs_val; end
          OP_XOR:  begin wr_en = 1'b1; wr_val = rd_val ^ rs_val; end
          OP_SLL:  begin wr_en = 1'b1; wr_val = rd_val << rs_val[3:0]; end
          OP_SRL:  begin wr_en = 1'b1; wr_val = rd_val >> rs_val[3:0]; end
          OP_SLT:  begin
            wr_en  = 1'b1;
            wr_val = ($signed(rd_val) < $signed(rs_val)) ? XLEN'(1) : XLEN'(0);
          end
`ifdef KTC16_MUL_EN
          OP_MUL:  begin wr_en = 1'b1; wr_val = mul_full[XLEN-1:0]; end
`endif
          OP_ADDI: begin wr_en = 1'b1; wr_val = ea; end
          OP_ANDI: begin wr_en = 1'b1; wr_val = rs_val & imm; end
          OP_ORI:  begin wr_en = 1'b1; wr_val = rs_val | imm; end
          OP_LW:   begin
            addr   = ea;
            wr_en  = 1'b1;
            wr_val = rd[XLEN-1:0];
          end
          OP_SW:   begin
            addr     = ea;
            memwrite = 1'b1;
            wd       = rd_val;
          end
          OP_BEQ:  if (rd_val == rs_val) pc_d = pc_q + imm;
          OP_BNE:  if (rd_val != rs_val) pc_d = pc_q + imm;
          // Target uses the pre-link rs, so d==s still jumps to old rs+imm.
          OP_JAL:  begin
            pc_d   = ea;
            wr_en  = 1'b1;
            wr_val = pc_plus4;
          end
          default: ;
        endcase
        if (wr_en && (d_idx != RIDX'(0))) regs_d[d_idx] = wr_val;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_ktc16.sv
// Directed bench for ktc16: per-opcode program table plus hand sequences for branches, JAL, LW/SW and reset.
module tb_ktc16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd;
  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] wd;

  ktc16 dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .memwrite (memwrite),
    .addr     (addr),
    .wd       (wd)
  );

  always #5 clk = ~clk;

  localparam int MW = 16384;
  logic [31:0] mem  [MW];
  logic [31:0] prog [MW];
  logic        ld_req;

  assign rd = mem[addr[15:2]];

  // Memory: bulk load from prog on request, otherwise word write on memwrite.
  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < MW; i++) mem[i] <= prog[i];
    end else if (memwrite) begin
      mem[addr[15:2]] <= {16'h0000, wd};
    end
  end

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Store log, sampled mid-cycle; cyc+1 is the cycle number ending at the next rising edge.
  int          st_n;
  logic [15:0] st_addr [8];
  logic [15:0] st_wd   [8];
  int          st_cyc  [8];
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      st_n <= 0;
    end else if (memwrite && st_n < 8) begin
      st_addr[st_n] <= addr;
      st_wd[st_n]   <= wd;
      st_cyc[st_n]  <= cyc + 1;
      st_n          <= st_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] d,
                                      input logic [3:0] s, input logic [15:0] imm);
    return {op, d, s, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < MW; i++) prog[i] = 32'h0;
  endtask

  // Reset with program load, then release and run ncyc clock cycles.
  task automatic run(input int ncyc, input bit chk_rst);
    reset  = 1'b0;
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    @(negedge clk);
    if (chk_rst) begin
      chk("reset_memwrite", 32'(memwrite), 32'h0);
      chk("reset_addr", 32'(addr), 32'h0);
      chk("reset_wd", 32'(wd), 32'h0);
    end
    reset = 1'b1;
    repeat (ncyc) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    reset  = 1'b0;
    ld_req = 1'b0;

    // r1=a, r2=b, then instr (d=1, s=2), result stored from r1 to address 84.
    vt[0]  = '{"add",   enc(8'h01, 4'd1, 4'd2, 16'h0000), 16'h0003, 16'h0004, 16'h0007};
    vt[1]  = '{"sub",   enc(8'h02, 4'd1, 4'd2, 16'h0000), 16'h0003, 16'h0005, 16'hFFFE};
    vt[2]  = '{"and",   enc(8'h03, 4'd1, 4'd2, 16'h0000), 16'hF0F0, 16'hFF00, 16'hF000};
    vt[3]  = '{"or",    enc(8'h04, 4'd1, 4'd2, 16'h0000), 16'hF0F0, 16'h0F0F, 16'hFFFF};
    vt[4]  = '{"xor",   enc(8'h05, 4'd1, 4'd2, 16'h0000), 16'hFFFF, 16'h00FF, 16'hFF00};
    vt[5]  = '{"sll",   enc(8'h06, 4'd1, 4'd2, 16'h0000), 16'h0001, 16'h0013, 16'h0008};
    vt[6]  = '{"srl",   enc(8'h07, 4'd1, 4'd2, 16'h0000), 16'h8000, 16'h000F, 16'h0001};
    vt[7]  = '{"slt_t", enc(8'h09, 4'd1, 4'd2, 16'h0000), 16'hFFFF, 16'h0001, 16'h0001};
    vt[8]  = '{"slt_f", enc(8'h09, 4'd1, 4'd2, 16'h0000), 16'h0001, 16'hFFFF, 16'h0000};
    vt[9]  = '{"addi",  enc(8'h10, 4'd1, 4'd2, 16'h0001), 16'h0005, 16'hFFFF, 16'h0000};
    vt[10] = '{"andi",  enc(8'h12, 4'd1, 4'd2, 16'h0FF0), 16'h0005, 16'h1234, 16'h0230};
    vt[11] = '{"ori",   enc(8'h13, 4'd1, 4'd2, 16'hF000), 16'h0005, 16'h0034, 16'hF034};
    vt[12] = '{"nop00", enc(8'h00, 4'd1, 4'd2, 16'hFFFF), 16'h5A5A, 16'h0001, 16'h5A5A};
    vt[13] = '{"undef", enc(8'h0B, 4'd1, 4'd2, 16'h00FF), 16'h1111, 16'h0002, 16'h1111};
`ifdef KTC16_MUL_EN
    vt[14] = '{"op08",  enc(8'h08, 4'd1, 4'd2, 16'h0000), 16'h0003, 16'h0005, 16'h000F};
`else
    vt[14] = '{"op08",  enc(8'h08, 4'd1, 4'd2, 16'h0000), 16'h0003, 16'h0005, 16'h0003};
`endif

    for (int v = 0; v < NV; v++) begin
      clear_prog();
      prog[0] = enc(8'h10, 4'd1, 4'd0, vt[v].a);
      prog[1] = enc(8'h10, 4'd2, 4'd0, vt[v].b);
      prog[2] = vt[v].instr;
      prog[3] = enc(8'h15, 4'd1, 4'd0, 16'd84);
      run(10, v == 0);
      chk({vt[v].name, "_nstores"}, 32'(st_n), 32'd1);
      chk({vt[v].name, "_wd"}, 32'(st_wd[0]), 32'(vt[v].exp));
      chk({vt[v].name, "_addr"}, 32'(st_addr[0]), 32'd84);
      if (v == 0) chk("add_store_cycle", 32'(st_cyc[0]), 32'd8);
    end

    // Store, load back, store again.
    clear_prog();
    prog[0] = enc(8'h10, 4'd3, 4'd0, 16'd5);
    prog[1] = enc(8'h15, 4'd3, 4'd0, 16'd80);
    prog[2] = enc(8'h14, 4'd4, 4'd0, 16'd80);
    prog[3] = enc(8'h15, 4'd4, 4'd0, 16'd84);
    run(10, 1'b0);
    chk("lw_nstores", 32'(st_n), 32'd2);
    chk("lw_st0_addr", 32'(st_addr[0]), 32'd80);
    chk("lw_st0_wd", 32'(st_wd[0]), 32'd5);
    chk("lw_st1_addr", 32'(st_addr[1]), 32'd84);
    chk("lw_st1_wd", 32'(st_wd[1]), 32'd5);
    chk("lw_mem84", mem[21], 32'd5);

    // Taken BNE skips the store at 8.
    clear_prog();
    prog[0] = enc(8'h10, 4'd1, 4'd0, 16'd1);
    prog[1] = enc(8'h17, 4'd1, 4'd0, 16'd8);
    prog[2] = enc(8'h15, 4'd1, 4'd0, 16'd84);
    prog[3] = enc(8'h15, 4'd1, 4'd0, 16'd80);
    run(10, 1'b0);
    chk("bne_nstores", 32'(st_n), 32'd1);
    chk("bne_addr", 32'(st_addr[0]), 32'd80);
    chk("bne_wd", 32'(st_wd[0]), 32'd1);
    chk("bne_cycle", 32'(st_cyc[0]), 32'd6);

    // r0 immutable, then 16-bit wrap of FFFF+1.
    clear_prog();
    prog[0] = enc(8'h10, 4'd0, 4'd0, 16'd9);
    prog[1] = enc(8'h15, 4'd0, 4'd0, 16'd84);
    prog[2] = enc(8'h10, 4'd1, 4'd0, 16'hFFFF);
    prog[3] = enc(8'h10, 4'd1, 4'd1, 16'd1);
    prog[4] = enc(8'h15, 4'd1, 4'd0, 16'd80);
    run(12, 1'b0);
    chk("r0_nstores", 32'(st_n), 32'd2);
    chk("r0_addr", 32'(st_addr[0]), 32'd84);
    chk("r0_wd", 32'(st_wd[0]), 32'd0);
    chk("wrap_addr", 32'(st_addr[1]), 32'd80);
    chk("wrap_wd", 32'(st_wd[1]), 32'd0);

    // JAL with d==s uses old rs for the target; then a taken BEQ.
    clear_prog();
    prog[0]  = enc(8'h10, 4'd5, 4'd0, 16'd20);
    prog[1]  = enc(8'h18, 4'd5, 4'd5, 16'd4);
    prog[2]  = enc(8'h15, 4'd5, 4'd0, 16'd80);
    prog[3]  = enc(8'h15, 4'd0, 4'd0, 16'd88);
    prog[6]  = enc(8'h15, 4'd5, 4'd0, 16'd84);
    prog[7]  = enc(8'h16, 4'd0, 4'd0, 16'd8);
    prog[8]  = enc(8'h15, 4'd5, 4'd0, 16'd80);
    prog[9]  = enc(8'h10, 4'd6, 4'd0, 16'h0077);
    prog[10] = enc(8'h15, 4'd6, 4'd0, 16'd80);
    run(14, 1'b0);
    chk("jal_nstores", 32'(st_n), 32'd2);
    chk("jal_addr", 32'(st_addr[0]), 32'd84);
    chk("jal_link", 32'(st_wd[0]), 32'd8);
    chk("jal_cycle", 32'(st_cyc[0]), 32'd6);
    chk("beq_addr", 32'(st_addr[1]), 32'd80);
    chk("beq_wd", 32'(st_wd[1]), 32'h77);
    chk("beq_cycle", 32'(st_cyc[1]), 32'd12);

    // Reset asserted in the middle of a SW EXEC cycle.
    clear_prog();
    prog[0]  = enc(8'h10, 4'd1, 4'd0, 16'h1234);
    prog[1]  = enc(8'h15, 4'd1, 4'd0, 16'd80);
    prog[20] = 32'h0000_CAFE;
    run(3, 1'b0);
    chk("rst_sw_active", 32'(memwrite), 32'h1);
    chk("rst_sw_addr", 32'(addr), 32'd80);
    #1 reset = 1'b0;
    #1;
    chk("rst_memwrite_drop", 32'(memwrite), 32'h0);
    chk("rst_addr_pc0", 32'(addr), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_unchanged", mem[20], 32'h0000_CAFE);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_restart_nstores", 32'(st_n), 32'd1);
    chk("rst_restart_cycle", 32'(st_cyc[0]), 32'd4);
    chk("rst_restart_mem", mem[20], 32'h0000_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ktc16.md
KTC16 -- requirements
Module: ktc16

Interface
REQ-001 The port list SHALL be, in order: clk, reset, rd, memwrite, addr, wd.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rd  input  32  memory read data; combinational word at addr (instruction fetch or load).
REQ-005 memwrite  output  1  memory write strobe; memory writes wd at addr on the rising edge while high.
REQ-006 addr  output  16  byte address; memory uses addr[15:2] as the word index.
REQ-007 wd  output  16  store data.

Function
REQ-008 The block SHALL be a multicycle CPU with two states: FETCH (addr=PC, IR<=rd at the clock edge, go to EXEC) and EXEC (execute IR, return to FETCH).
REQ-009 Architectural state SHALL be: 16-bit PC; 16 registers r0..r15 of 16 bits; r0 reads 0 and ignores writes.
REQ-010 Instruction format SHALL be: op=IR[31:24], d=IR[23:20], s=IR[19:16], imm=IR[15:0]; t=imm[3:0] for register ops.
REQ-011 Register ops SHALL be: 01 ADD rd=rd+rs; 02 SUB rd=rd-rs; 03 AND; 04 OR; 05 XOR; 06 SLL rd=rd<<rs[3:0]; 07 SRL (logical); 09 SLT rd=(signed rd<rs)?1:0.
REQ-012 Immediate ops SHALL be: 10 ADDI rd=rs+imm; 12 ANDI; 13 ORI; 14 LW rd=rd_bus[15:0] with addr=rs+imm; 15 SW mem[rs+imm]=rd.
REQ-013 Control ops SHALL be: 16 BEQ, if rd==rs then PC=PC+imm; 17 BNE; 18 JAL, rd=PC+4 and PC=rs+imm.
REQ-014 PC SHALL be PC+4 after every non-taken instruction; branch offsets are relative to the instruction's own address.
REQ-015 Opcode 00 and all undefined opcodes SHALL execute as NOP.
REQ-016 All arithmetic SHALL be 16-bit modulo 2^16, with no flags and no traps; PC wraps from FFFC to 0000.
REQ-017 memwrite SHALL be 1 only in EXEC of SW, with addr=rs+imm and wd=rd held stable for that entire cycle; it is 0 in FETCH and for all other ops.
REQ-018 In EXEC, addr SHALL be rs+imm for LW/SW and PC otherwise; wd SHALL be 0 when memwrite=0.
REQ-019 Register write-back and PC update SHALL occur at the rising edge ending EXEC; LW data is sampled at that edge.
REQ-020 A JAL with d==s SHALL compute the target from the old rs before the link write.

Reset
REQ-021 While reset=0, the block SHALL force PC=0, state=FETCH, IR=0, and all registers to 0; memwrite=0 immediately (asynchronously).
REQ-022 After reset deasserts, the first fetch SHALL be from address 0 on the next rising edge.
REQ-023 Reset asserted mid-EXEC of SW SHALL drop memwrite at once, and no write SHALL occur.

Configuration
REQ-024 With KTC16_MUL_EN defined, opcode 08 SHALL be MUL: rd = low 16 bits of rd*rs, unsigned, completing in a single EXEC cycle.
REQ-025 Without KTC16_MUL_EN, opcode 08 SHALL be a NOP, and no multiplier logic SHALL be synthesized.

Verification
REQ-026 Reset then run program ADDI r1,r0,3; ADDI r2,r0,4; ADD r1,r2; SW r1,84(r0) -> the only memwrite has addr=84, wd=7, in cycle 8 after reset release.
REQ-027 ADDI r3,r0,5; SW r3,80(r0); LW r4,80(r0); SW r4,84(r0) -> memwrite at addr 80 with wd=5, then at addr 84 with wd=5.
REQ-028 ADDI r1,r0,1; BNE r1,r0,+8; SW r1,84(r0); SW r1,80(r0) -> the store at addr 84 is skipped and addr 80 receives wd=1.
REQ-029 ADDI r0,r0,9; SW r0,84(r0) -> wd=0 (r0 immutable); ADDI r1,r0,FFFF; ADDI r1,r1,1; SW r1,80(r0) -> wd=0 (wrap).
REQ-030 Assert reset during EXEC of SW -> memwrite falls within the same cycle, the memory word is unchanged, and PC restarts at 0.
